drum_timing_sequencer: RTL and testbench

Sequencer that drives the drum timing-control memory. It steps the 6-bit sector address and the half-sector phase bit through one or more drum rotations, and enables the memory's chip-enable and output-enable. It registers the returned 8-bit control word into stable control outputs for the arithmetic and carry datapath. It sits between the top-level run controller (start/stop handshake) and the timing memory.

---
 rtl/drum_timing_pkg.sv | 29 ++
 rtl/drum_step_counter.sv | 51 +++++
 rtl/drum_timing_sequencer.sv | 177 +++++++++++++++++
 tb/tb_drum_timing_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_timing_pkg.sv
// Shared types and constants for the drum timing sequencer: FSM state encoding,
// control-word bit positions and the control word seen while the memory is idle.
package drum_timing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    localparam int READ_B          = 0;
    localparam int CONTROL_B       = 1;
    localparam int LAST_READ_B     = 2;
    localparam int LAST_WRITE_B    = 3;
    localparam int CLEAR_CONTROL_B = 4;
    localparam int CHECK_B         = 5;
    localparam int CLEAR_FLAGS_B   = 6;
    localparam int RSTCNT_N_B      = 7;

    // Only resetCounter_n (active low) is high when nothing is being read.
    localparam logic [7:0] CTRL_RESET = 8'h80;

    // The memory is enabled and its word is sampled only in these states.
    function automatic logic mem_active(input seq_state_t s);
        return (s == PRIME) || (s == RUN);
    endfunction

endpackage

// File: rtl/drum_step_counter.sv
// Sector address / half-sector phase / rotation counter. Each step toggles the
// phase; the step that takes the phase from 1 to 0 advances or wraps the address.
module drum_step_counter
    import drum_timing_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int ROT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              wrap_hint,
    input  logic              clear,
    output logic [ADDR_W-1:0] addr,
    output logic              phase,
    output logic [ROT_W-1:0]  rot_cnt,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ROT_W-1:0]  ROT_MAX  = '1;

    // A wrap happens on the second half-sector step of the last sector, where the
    // last sector is marked by the memory or by the top of the address range.
    assign wrap = step && phase && (wrap_hint || (addr == ADDR_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr    <= '0;
            phase   <= 1'b0;
            rot_cnt <= '0;
        end else if (clear) begin
            addr    <= '0;
            phase   <= 1'b0;
            rot_cnt <= '0;
        end else if (step) begin
            phase <= ~phase;
            if (phase) begin
                if (wrap) begin
                    addr <= '0;
                    if (rot_cnt != ROT_MAX) begin
                        rot_cnt <= rot_cnt + ROT_W'(1);
                    end
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/drum_timing_sequencer.sv
// Drum timing-memory sequencer: steps the memory through whole rotations and
// registers its control word. Define SEQ_WATCHDOG_EN to add a missing-tick abort.
module drum_timing_sequencer
    import drum_timing_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int ROT_W  = 4
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ROT_W-1:0]  rotations,
    input  logic              sector_tick,
    input  logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_phase,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              busy,
    output logic              done,
    output logic [ROT_W-1:0]  rot_cnt,
    output logic              read,
    output logic              control,
    output logic              lastRead,
    output logic              lastWrite,
    output logic              clearControl,
    output logic              check,
    output logic              clearFlags,
    output logic              resetCounter_n,
    output seq_state_t        fsm_state
`ifdef SEQ_WATCHDOG_EN
    ,
    output logic              wdog_err
`endif
);

    seq_state_t state;
    seq_state_t next_state;
    logic       stop_pending;
    logic [7:0] ctrl_q;
    logic       done_q;
    logic       accept_start;
    logic       step;
    logic       wrap;
    logic       run_end;
    logic       wdog_hit;

    assign accept_start = (state == IDLE) && start;
    assign step         = (state == RUN) && sector_tick;

    // Handshake: start is a one-cycle request honoured only in IDLE; stop is a
    // level sampled in PRIME/RUN and remembered until the run ends at a wrap.
    assign run_end = wrap &&
                     (((rotations != '0) && ((rot_cnt + ROT_W'(1)) == rotations)) ||
                      stop_pending);

    drum_step_counter #(
        .ADDR_W(ADDR_W),
        .ROT_W (ROT_W)
    ) u_step (
        .clk      (clk),
        .reset    (reset),
        .step     (step),
        .wrap_hint(~mem_data[RSTCNT_N_B]),
        .clear    (accept_start),
        .addr     (mem_addr),
        .phase    (mem_phase),
        .rot_cnt  (rot_cnt),
        .wrap     (wrap)
    );

`ifdef SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;

    // The cycle that would bring the count to WDOG_CYCLES aborts the run.
    assign wdog_hit = (state == RUN) && !sector_tick &&
                      (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if ((state != RUN) || sector_tick) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
            if (accept_start) begin
                wdog_err <= 1'b0;
            end else if (wdog_hit) begin
                wdog_err <= 1'b1;
            end
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PRIME;
            PRIME:   next_state = RUN;
            RUN:     if (run_end || wdog_hit) next_state = DRAIN;
            DRAIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_ce_n = 1'b1;
        mem_oe_n = 1'b1;
        busy     = 1'b0;
        case (state)
            PRIME, RUN: begin
                mem_ce_n = 1'b0;
                mem_oe_n = 1'b0;
                busy     = 1'b1;
            end
            DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    assign mem_we_n  = 1'b1;
    assign fsm_state = state;

    // The word is sampled every enabled cycle; the cycle that leaves RUN loads
    // the idle word instead so DRAIN already presents quiet control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stop_pending <= 1'b0;
            ctrl_q       <= CTRL_RESET;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state == DRAIN);
            if (state == IDLE) begin
                stop_pending <= 1'b0;
            end else if (mem_active(state) && stop) begin
                stop_pending <= 1'b1;
            end
            if (mem_active(state) && (next_state != DRAIN)) begin
                ctrl_q <= mem_data;
            end else begin
                ctrl_q <= CTRL_RESET;
            end
        end
    end

    assign done           = done_q;
    assign read           = ctrl_q[READ_B];
    assign control        = ctrl_q[CONTROL_B];
    assign lastRead       = ctrl_q[LAST_READ_B];
    assign lastWrite      = ctrl_q[LAST_WRITE_B];
    assign clearControl   = ctrl_q[CLEAR_CONTROL_B];
    assign check          = ctrl_q[CHECK_B];
    assign clearFlags     = ctrl_q[CLEAR_FLAGS_B];
    assign resetCounter_n = ctrl_q[RSTCNT_N_B];

endmodule

// File: tb/tb_drum_timing_sequencer.sv
// Directed bench for drum_timing_sequencer with a behavioural timing-memory model.
// Build with SEQ_WATCHDOG_EN defined to include the watchdog scenario.
module tb_drum_timing_sequencer;
    import drum_timing_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [3:0] rotations;
    logic       sector_tick;
    logic [7:0] mem_data;
    logic [5:0] mem_addr;
    logic       mem_phase;
    logic       mem_ce_n;
    logic       mem_oe_n;
    logic       mem_we_n;
    logic       busy;
    logic       done;
    logic [3:0] rot_cnt;
    logic       read;
    logic       control;
    logic       lastRead;
    logic       lastWrite;
    logic       clearControl;
    logic       check;
    logic       clearFlags;
    logic       resetCounter_n;
    seq_state_t fsm_state;
`ifdef SEQ_WATCHDOG_EN
    logic       wdog_err;
`endif
    logic [7:0] ctrl_out;

    int checks   = 0;
    int failures = 0;

    // Statistics gathered by run_to_end for the scenario tasks to judge.
    int         run_steps;
    logic [3:0] run_rot;
    logic       run_ended;
    int         lw_hits, lr_hits, ck_hits, pos_bad, ctl_bad, read_bad;

    always #5 clk = ~clk;

    drum_timing_sequencer #(
        .ADDR_W(6),
        .ROT_W (4)
`ifdef SEQ_WATCHDOG_EN
        ,
        .WDOG_CYCLES(16)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .rotations     (rotations),
        .sector_tick   (sector_tick),
        .mem_data      (mem_data),
        .mem_addr      (mem_addr),
        .mem_phase     (mem_phase),
        .mem_ce_n      (mem_ce_n),
        .mem_oe_n      (mem_oe_n),
        .mem_we_n      (mem_we_n),
        .busy          (busy),
        .done          (done),
        .rot_cnt       (rot_cnt),
        .read          (read),
        .control       (control),
        .lastRead      (lastRead),
        .lastWrite     (lastWrite),
        .clearControl  (clearControl),
        .check         (check),
        .clearFlags    (clearFlags),
        .resetCounter_n(resetCounter_n),
        .fsm_state     (fsm_state)
`ifdef SEQ_WATCHDOG_EN
        ,
        .wdog_err      (wdog_err)
`endif
    );

    // Timing memory contents, word index = {sector address, phase}.
    function automatic logic [7:0] mem_model(input logic [6:0] w);
        logic [7:0] d;
        d = w[0] ? 8'h81 : 8'h80;
        if (w >= 7'd100) d = d | 8'h02;
        if (w == 7'd99)  d = d | 8'h04;
        if (w == 7'd98)  d = d | 8'h08;
        if (w == 7'd102) d = d | 8'h10;
        if (w == 7'd104) d = d | 8'h20;
        if (w == 7'd106) d = d | 8'h40;
        if (w == 7'd118 || w == 7'd119) d = d & 8'h7F;
        return d;
    endfunction

    assign mem_data = mem_model({mem_addr, mem_phase});
    assign ctrl_out = {resetCounter_n, clearFlags, check, clearControl,
                       lastWrite, lastRead, control, read};

    task automatic apply_reset();
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        sector_tick = 1'b0;
        rotations   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Starts a run and follows it cycle by cycle until the model predicts DRAIN.
    task automatic run_to_end(input logic [3:0] rot_req, input int gap,
                              input logic use_stop, input logic [3:0] stop_rot,
                              input logic [5:0] stop_addr, input logic stop_at_start);
        logic [5:0] m_addr, p_addr;
        logic       m_phase, p_phase, m_stop, tick, wrapped;
        logic [3:0] m_rot;
        logic [7:0] live;
        int         cyc;
        run_steps = 0; run_ended = 1'b0;
        lw_hits = 0; lr_hits = 0; ck_hits = 0; pos_bad = 0; ctl_bad = 0; read_bad = 0;
        start = 1'b1; stop = stop_at_start; rotations = rot_req;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        checks++;
        if (fsm_state !== PRIME || mem_ce_n !== 1'b0 || mem_oe_n !== 1'b0 || busy !== 1'b1 ||
            mem_addr !== 6'd0 || mem_phase !== 1'b0 || rot_cnt !== 4'd0) begin
            failures++;
            $display("FAIL prime_entry: state=%0d ce_n=%b oe_n=%b busy=%b addr=%0d phase=%b rot=%0d required state=1 ce_n=0 oe_n=0 busy=1 addr=0 phase=0 rot=0",
                     fsm_state, mem_ce_n, mem_oe_n, busy, mem_addr, mem_phase, rot_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (fsm_state !== RUN || ctrl_out !== 8'h80) begin
            failures++;
            $display("FAIL prime_capture: state=%0d ctrl=%h required state=2 ctrl=80", fsm_state, ctrl_out);
        end
        m_addr = 6'd0; m_phase = 1'b0; m_rot = 4'd0; m_stop = 1'b0; cyc = 0;
        while (!run_ended && cyc < 2000) begin
            live = mem_model({m_addr, m_phase});
            p_addr = m_addr; p_phase = m_phase;
            checks++;
            if (mem_addr !== m_addr || mem_phase !== m_phase) begin
                failures++;
                $display("FAIL position cyc=%0d: addr=%0d phase=%b required addr=%0d phase=%b",
                         cyc, mem_addr, mem_phase, m_addr, m_phase);
            end
            tick = ((cyc % gap) == gap - 1);
            sector_tick = tick;
            stop = use_stop && !m_stop && m_rot == stop_rot && m_addr == stop_addr;
            @(posedge clk); #1;
            if (stop) m_stop = 1'b1;
            stop = 1'b0; sector_tick = 1'b0;
            wrapped = 1'b0;
            if (tick) begin
                run_steps++;
                if (!m_phase) begin
                    m_phase = 1'b1;
                end else begin
                    m_phase = 1'b0;
                    if (!live[7] || m_addr == 6'd63) begin
                        m_addr = 6'd0; wrapped = 1'b1;
                        if (m_rot != 4'hF) m_rot = m_rot + 4'd1;
                    end else begin
                        m_addr = m_addr + 6'd1;
                    end
                end
            end
            if (wrapped && ((rot_req != 4'd0 && m_rot == rot_req) || m_stop)) begin
                run_ended = 1'b1;
                checks++;
                if (fsm_state !== DRAIN || mem_ce_n !== 1'b1 || mem_oe_n !== 1'b1 ||
                    busy !== 1'b1 || ctrl_out !== 8'h80 || mem_addr !== 6'd0) begin
                    failures++;
                    $display("FAIL drain_entry: state=%0d ce_n=%b oe_n=%b busy=%b ctrl=%h addr=%0d required state=3 ce_n=1 oe_n=1 busy=1 ctrl=80 addr=0",
                             fsm_state, mem_ce_n, mem_oe_n, busy, ctrl_out, mem_addr);
                end
            end else begin
                checks++;
                if (ctrl_out !== live || fsm_state !== RUN) begin
                    failures++;
                    $display("FAIL ctrl_capture cyc=%0d: ctrl=%h state=%0d required ctrl=%h state=2",
                             cyc, ctrl_out, fsm_state, live);
                end
                if (lastWrite) begin lw_hits++; if (!(p_addr == 6'd49 && !p_phase)) pos_bad++; end
                if (lastRead)  begin lr_hits++; if (!(p_addr == 6'd49 &&  p_phase)) pos_bad++; end
                if (check)     begin ck_hits++; if (!(p_addr == 6'd52 && !p_phase)) pos_bad++; end
                if (control !== (p_addr >= 6'd50)) ctl_bad++;
                if (read !== p_phase) read_bad++;
            end
            cyc++;
        end
        run_rot = m_rot;
        if (!run_ended) begin
            checks++; failures++;
            $display("FAIL run_timeout: run still going after %0d cycles, required DRAIN", cyc);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (fsm_state !== IDLE || mem_addr !== 6'd0 || mem_phase !== 1'b0 || mem_ce_n !== 1'b1 ||
            mem_oe_n !== 1'b1 || mem_we_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            rot_cnt !== 4'd0 || ctrl_out !== 8'h80) begin
            failures++;
            $display("FAIL reset_values: state=%0d addr=%0d phase=%b ce_n=%b oe_n=%b we_n=%b busy=%b done=%b rot=%0d ctrl=%h required 0/0/0/1/1/1/0/0/0/80",
                     fsm_state, mem_addr, mem_phase, mem_ce_n, mem_oe_n, mem_we_n, busy, done, rot_cnt, ctrl_out);
        end
`ifdef SEQ_WATCHDOG_EN
        checks++;
        if (wdog_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_wdog: wdog_err=%b required 0", wdog_err);
        end
`endif
        sector_tick = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        sector_tick = 1'b0; stop = 1'b0;
        checks++;
        if (fsm_state !== IDLE || mem_addr !== 6'd0 || mem_phase !== 1'b0 || ctrl_out !== 8'h80) begin
            failures++;
            $display("FAIL idle_hold: state=%0d addr=%0d phase=%b ctrl=%h required state=0 addr=0 phase=0 ctrl=80",
                     fsm_state, mem_addr, mem_phase, ctrl_out);
        end
    endtask

    task automatic test_single_rotation();
        run_to_end(4'd1, 4, 1'b0, 4'd0, 6'd0, 1'b0);
        checks++;
        if (run_steps != 120 || rot_cnt !== 4'd1) begin
            failures++;
            $display("FAIL single_rot_len: steps=%0d rot=%0d required steps=120 rot=1", run_steps, rot_cnt);
        end
        checks++;
        if (lw_hits != 4 || lr_hits != 4 || ck_hits != 4 || pos_bad != 0) begin
            failures++;
            $display("FAIL flag_positions: lastWrite=%0d lastRead=%0d check=%0d misplaced=%0d required 4/4/4/0",
                     lw_hits, lr_hits, ck_hits, pos_bad);
        end
        checks++;
        if (ctl_bad != 0 || read_bad != 0) begin
            failures++;
            $display("FAIL control_read: control_errs=%0d read_errs=%0d required 0/0", ctl_bad, read_bad);
        end
        @(posedge clk); #1;
        checks++;
        if (fsm_state !== IDLE || done !== 1'b1 || busy !== 1'b0 || mem_ce_n !== 1'b1 ||
            mem_oe_n !== 1'b1 || rot_cnt !== 4'd1 || ctrl_out !== 8'h80) begin
            failures++;
            $display("FAIL done_pulse: state=%0d done=%b busy=%b ce_n=%b oe_n=%b rot=%0d ctrl=%h required 0/1/0/1/1/1/80",
                     fsm_state, done, busy, mem_ce_n, mem_oe_n, rot_cnt, ctrl_out);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || rot_cnt !== 4'd1) begin
            failures++;
            $display("FAIL done_single: done=%b rot=%0d required done=0 rot=1", done, rot_cnt);
        end
    endtask

    task automatic test_stop_mid_run();
        // The stop presented with start must be dropped; the later one ends the run.
        run_to_end(4'd0, 2, 1'b1, 4'd1, 6'd20, 1'b1);
        checks++;
        if (run_steps != 240 || rot_cnt !== 4'd2 || run_rot !== 4'd2) begin
            failures++;
            $display("FAIL stop_len: steps=%0d rot=%0d required steps=240 rot=2", run_steps, rot_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || fsm_state !== IDLE || rot_cnt !== 4'd2) begin
            failures++;
            $display("FAIL stop_done: done=%b state=%0d rot=%0d required done=1 state=0 rot=2", done, fsm_state, rot_cnt);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; rotations = 4'd0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        sector_tick = 1'b1; @(posedge clk); #1; sector_tick = 1'b0;
        @(posedge clk); #1;
        sector_tick = 1'b1; @(posedge clk); #1; sector_tick = 1'b0;
        checks++;
        if (mem_addr !== 6'd1 || mem_phase !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pre: addr=%0d phase=%b required addr=1 phase=0", mem_addr, mem_phase);
        end
        start = 1'b1; sector_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (fsm_state !== RUN || mem_ce_n !== 1'b0) begin
                failures++;
                $display("FAIL b2b_no_restart %0d: state=%0d ce_n=%b required state=2 ce_n=0", i, fsm_state, mem_ce_n);
            end
        end
        start = 1'b0; sector_tick = 1'b0;
        checks++;
        if (mem_addr !== 6'd2 || mem_phase !== 1'b1 || rot_cnt !== 4'd0 || ctrl_out !== 8'h80) begin
            failures++;
            $display("FAIL b2b_steps: addr=%0d phase=%b rot=%0d ctrl=%h required addr=2 phase=1 rot=0 ctrl=80",
                     mem_addr, mem_phase, rot_cnt, ctrl_out);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; rotations = 4'd0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        sector_tick = 1'b1;
        repeat (60) @(posedge clk);
        #1; sector_tick = 1'b0;
        checks++;
        if (mem_addr !== 6'd30 || mem_phase !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_pos: addr=%0d phase=%b busy=%b required addr=30 phase=0 busy=1", mem_addr, mem_phase, busy);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (fsm_state !== IDLE || mem_addr !== 6'd0 || mem_phase !== 1'b0 || mem_ce_n !== 1'b1 ||
            mem_oe_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rot_cnt !== 4'd0 || ctrl_out !== 8'h80) begin
            failures++;
            $display("FAIL async_reset: state=%0d addr=%0d phase=%b ce_n=%b oe_n=%b busy=%b done=%b rot=%0d ctrl=%h required 0/0/0/1/1/0/0/0/80",
                     fsm_state, mem_addr, mem_phase, mem_ce_n, mem_oe_n, busy, done, rot_cnt, ctrl_out);
        end
        @(posedge clk); #1; reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || fsm_state !== IDLE) begin
                failures++;
                $display("FAIL no_done_after_reset %0d: done=%b state=%0d required done=0 state=0", i, done, fsm_state);
            end
        end
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (fsm_state !== PRIME || mem_addr !== 6'd0 || mem_phase !== 1'b0 || mem_ce_n !== 1'b0) begin
            failures++;
            $display("FAIL restart: state=%0d addr=%0d phase=%b ce_n=%b required state=1 addr=0 phase=0 ce_n=0",
                     fsm_state, mem_addr, mem_phase, mem_ce_n);
        end
        @(posedge clk); #1;
        sector_tick = 1'b1; @(posedge clk); #1; sector_tick = 1'b0;
        checks++;
        if (mem_addr !== 6'd0 || mem_phase !== 1'b1) begin
            failures++;
            $display("FAIL restart_step: addr=%0d phase=%b required addr=0 phase=1", mem_addr, mem_phase);
        end
        apply_reset();
    endtask

`ifdef SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        start = 1'b1; rotations = 4'd0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            checks++;
            if (fsm_state !== RUN || wdog_err !== 1'b0) begin
                failures++;
                $display("FAIL wdog_early %0d: state=%0d wdog_err=%b required state=2 wdog_err=0", i, fsm_state, wdog_err);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (fsm_state !== DRAIN || wdog_err !== 1'b1 || mem_ce_n !== 1'b1) begin
            failures++;
            $display("FAIL wdog_abort: state=%0d wdog_err=%b ce_n=%b required state=3 wdog_err=1 ce_n=1", fsm_state, wdog_err, mem_ce_n);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || wdog_err !== 1'b1) begin
            failures++;
            $display("FAIL wdog_done: done=%b wdog_err=%b required done=1 wdog_err=1", done, wdog_err);
        end
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (wdog_err !== 1'b0 || fsm_state !== PRIME) begin
            failures++;
            $display("FAIL wdog_clear: wdog_err=%b state=%0d required wdog_err=0 state=1", wdog_err, fsm_state);
        end
        apply_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single_rotation();
        test_stop_mid_run();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
